// File: rtl/opal_pkg.sv
// Shared types and widths for the OPAL link block (transmit and receive paths).
package opal_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, HOLD} opal_tx_state_t;
  localparam int OPAL_BYTE_W = 8;
  localparam int OPAL_CNT_W  = 16;
endpackage

// File: rtl/opal_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level plus a registered rising-edge pulse.
// o_level lags i_async by SYNC_STAGES cycles; o_rise pulses SYNC_STAGES+1 cycles after a rise.
module opal_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level_d;
  logic                   r_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync    <= '0;
      r_level_d <= 1'b0;
      r_rise    <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_level_d <= r_sync[SYNC_STAGES-1];
      r_rise    <= r_sync[SYNC_STAGES-1] & ~r_level_d;
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_rise;
endmodule

// File: rtl/opal_tx_sequencer.sv
// Sends a latched NUM_BYTES frame to OPAL as strobed 8-bit words, one frame per enable rise.
// Each byte: HALF_PERIOD cycles setup (strobe low) then HALF_PERIOD cycles hold (strobe high).
module opal_tx_sequencer
  import opal_pkg::*;
#(
  parameter int NUM_BYTES   = 16,
  parameter int HALF_PERIOD = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_enable,
  input  logic [NUM_BYTES*OPAL_BYTE_W-1:0] i_payload,
  input  logic                             i_clr_overrun,
  output logic [OPAL_BYTE_W-1:0]           o_data,
  output logic                             o_strobe,
  output logic                             o_frame,
  output logic                             o_done,
  output logic                             o_overrun,
  output logic [OPAL_CNT_W-1:0]            o_frame_cnt
);
  localparam int PH_W  = $clog2(HALF_PERIOD + 1);
  localparam int IDX_W = $clog2(NUM_BYTES + 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(HALF_PERIOD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BYTES - 1);

  opal_tx_state_t                   r_state;
  opal_tx_state_t                   w_state_nxt;
  logic [PH_W-1:0]                  r_phase;
  logic [IDX_W-1:0]                 r_idx;
  logic [NUM_BYTES*OPAL_BYTE_W-1:0] r_shadow;
  logic [OPAL_BYTE_W-1:0]           r_data;
  logic [OPAL_BYTE_W-1:0]           w_next_byte;
  logic                             r_strobe;
  logic                             r_frame;
  logic                             r_done;
  logic                             r_overrun;
  logic [OPAL_CNT_W-1:0]            r_frame_cnt;
  logic                             w_en_level;
  logic                             w_en_rise;
  logic                             w_phase_end;
  logic                             w_start;
  logic                             w_advance;
  logic                             w_finish;
  logic                             w_abort;

  opal_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
    .clk     (clk),
    .rst     (rst),
    .i_async (i_enable),
    .o_level (w_en_level),
    .o_rise  (w_en_rise)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_phase_end = (r_phase == PH_LAST);
    w_start     = 1'b0;
    w_advance   = 1'b0;
    w_finish    = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_en_rise) begin
          w_start     = 1'b1;
          w_state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (!w_en_level) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_phase_end) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!w_en_level) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_phase_end) begin
          if (r_idx == IDX_LAST) begin
            w_finish    = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_advance   = 1'b1;
            w_state_nxt = SETUP;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Byte for the next index comes from the shadow copy, never from the live payload.
  always_comb begin
    w_next_byte = '0;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (r_idx + IDX_W'(1) == IDX_W'(k)) w_next_byte = r_shadow[k*OPAL_BYTE_W +: OPAL_BYTE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase     <= '0;
      r_idx       <= '0;
      r_shadow    <= '0;
      r_data      <= '0;
      r_strobe    <= 1'b0;
      r_frame     <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_frame  <= (w_state_nxt != IDLE);
      r_strobe <= (w_state_nxt == HOLD);
      r_done   <= w_finish;
      if (r_state == IDLE || w_state_nxt != r_state) r_phase <= '0;
      else                                           r_phase <= r_phase + PH_W'(1);
      if (w_start) begin
        r_shadow <= i_payload;
        r_data   <= i_payload[OPAL_BYTE_W-1:0];
        r_idx    <= '0;
      end else if (w_advance) begin
        r_idx  <= r_idx + IDX_W'(1);
        r_data <= w_next_byte;
      end
      if (w_finish) r_frame_cnt <= r_frame_cnt + OPAL_CNT_W'(1);
      // An edge that coincides with the final hold ending is dropped, not flagged.
      if (w_en_rise && r_state != IDLE && !w_finish) r_overrun <= 1'b1;
      else if (i_clr_overrun)                        r_overrun <= 1'b0;
    end
  end

  assign o_data      = r_data;
  assign o_strobe    = r_strobe;
  assign o_frame     = r_frame;
  assign o_done      = r_done;
  assign o_overrun   = r_overrun;
  assign o_frame_cnt = r_frame_cnt;
endmodule

// File: tb/tb_opal_tx_sequencer.sv
// Scoreboard bench for opal_tx_sequencer: stimulus queues expected strobed bytes and frame
// counts, a monitor pops them on each strobe rise and done pulse.
module tb_opal_tx_sequencer;
  import opal_pkg::*;

  localparam int NB = 4;
  localparam int HP = 2;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_enable;
  logic [NB*8-1:0] i_payload;
  logic          i_clr_overrun;
  logic [7:0]    o_data;
  logic          o_strobe;
  logic          o_frame;
  logic          o_done;
  logic          o_overrun;
  logic [15:0]   o_frame_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_bytes[$];
  logic [15:0] exp_cnt[$];
  logic        mon_prev_s;

  always #5 clk = ~clk;

  opal_tx_sequencer #(.NUM_BYTES(NB), .HALF_PERIOD(HP), .SYNC_STAGES(SS)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_enable      (i_enable),
    .i_payload     (i_payload),
    .i_clr_overrun (i_clr_overrun),
    .o_data        (o_data),
    .o_strobe      (o_strobe),
    .o_frame       (o_frame),
    .o_done        (o_done),
    .o_overrun     (o_overrun),
    .o_frame_cnt   (o_frame_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_frame(input logic [31:0] p, input int nbytes, input bit with_done,
                            input logic [15:0] cnt);
    for (int k = 0; k < nbytes; k++) exp_bytes.push_back(p[8*k +: 8]);
    if (with_done) exp_cnt.push_back(cnt);
  endtask

  // Leaves the bench at the first cycle of the new frame.
  task automatic start_frame(input logic [31:0] p);
    i_enable = 1'b0;
    tick(3);
    i_payload = p;
    i_enable  = 1'b1;
    tick(4);
    chk("frame_start", 32'(o_frame), 32'd1);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (o_done !== 1'b1 && n < 40) begin
      tick(1);
      n++;
    end
    chk(name, 32'(o_done), 32'd1);
  endtask

  initial begin
    mon_prev_s = 1'b0;
    forever begin
      @(negedge clk);
      if (o_strobe === 1'b1 && mon_prev_s === 1'b0) begin
        if (exp_bytes.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_byte: unexpected strobe with data %0h, nothing expected", o_data);
        end else begin
          chk("sb_byte", 32'(o_data), 32'(exp_bytes.pop_front()));
        end
      end
      if (o_done === 1'b1) begin
        if (exp_cnt.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_done: unexpected o_done with count %0h, none expected", o_frame_cnt);
        end else begin
          chk("sb_done_cnt", 32'(o_frame_cnt), 32'(exp_cnt.pop_front()));
        end
      end
      mon_prev_s = o_strobe;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; i_enable = 1'b0; i_clr_overrun = 1'b0; i_payload = '0;
    tick(3);
    chk("reset_outputs", 32'({o_data, o_strobe, o_frame, o_done, o_overrun, o_frame_cnt}), 32'd0);
    chk("reset_state", 32'(dut.r_state), 32'(IDLE));
    rst = 1'b0;
    tick(2);

    // Reset during the hold phase of byte 2: bytes 0..2 have been strobed.
    push_frame(32'h0D0C0B0A, 3, 1'b0, 16'd0);
    start_frame(32'h0D0C0B0A);
    tick(10);
    chk("mid_hold_strobe", 32'(o_strobe), 32'd1);
    chk("mid_hold_idx", 32'(dut.r_idx), 32'd2);
    rst = 1'b1; i_enable = 1'b0;
    tick(1);
    chk("midrst_outputs", 32'({o_data, o_strobe, o_frame, o_done, o_overrun, o_frame_cnt}), 32'd0);
    chk("midrst_state", 32'(dut.r_state), 32'(IDLE));
    rst = 1'b0;
    tick(4);

    // Normal frame with latency and per-cycle strobe/data pattern.
    push_frame(32'h44332211, 4, 1'b1, 16'd1);
    i_payload = 32'h44332211;
    i_enable  = 1'b1;
    tick(3);
    chk("frame_not_yet", 32'(o_frame), 32'd0);
    tick(1);
    for (int c = 1; c <= 16; c++) begin
      chk("frame_high", 32'(o_frame), 32'd1);
      chk("strobe_pattern", 32'(o_strobe), 32'(((c - 1) / 2) % 2));
      chk("data_pattern", 32'(o_data), 32'(8'h11 * ((c - 1) / 4 + 1)));
      chk("no_early_done", 32'(o_done), 32'd0);
      if (c < 16) tick(1);
    end
    tick(1);
    chk("done_at_16", 32'(o_done), 32'd1);
    chk("frame_low_at_done", 32'({o_frame, o_strobe}), 32'd0);
    tick(1);
    chk("done_one_cycle", 32'(o_done), 32'd0);
    tick(5);
    chk("no_retrigger_on_level", 32'(o_frame), 32'd0);

    // Payload changes after the latch must not leak into the frame.
    push_frame(32'h44332211, 4, 1'b1, 16'd2);
    start_frame(32'h44332211);
    i_payload = 32'hDEADBEEF;
    wait_done("shadow_done");
    tick(1);
    chk("idle_holds_last", 32'(o_data), 32'h44);

    // Abort while byte 1 is in hold.
    push_frame(32'h87654321, 2, 1'b0, 16'd0);
    start_frame(32'h87654321);
    tick(6);
    chk("abort_pre_hold", 32'({o_strobe, o_data}), 32'h143);
    i_enable = 1'b0;
    n = 0;
    while ((o_frame !== 1'b0 || o_strobe !== 1'b0) && n < 4) begin
      tick(1);
      n++;
    end
    chk("abort_idle", 32'({o_frame, o_strobe}), 32'd0);
    tick(4);
    chk("abort_cnt", 32'(o_frame_cnt), 32'd2);
    chk("abort_state", 32'(dut.r_state), 32'(IDLE));
    chk("abort_no_overrun", 32'(o_overrun), 32'd0);

    // Overrun: enable glitches during byte 2 while the synced level is held high.
    push_frame(32'hCAFEF00D, 4, 1'b1, 16'd3);
    start_frame(32'hCAFEF00D);
    tick(8);
    force dut.w_en_level = 1'b1;
    i_enable = 1'b0;
    tick(2);
    i_enable = 1'b1;
    wait_done("ovr_done");
    release dut.w_en_level;
    chk("ovr_set", 32'(o_overrun), 32'd1);
    i_clr_overrun = 1'b1;
    tick(1);
    i_clr_overrun = 1'b0;
    chk("ovr_clear", 32'(o_overrun), 32'd0);

    // Clear coinciding with a new overrun edge: set wins.
    push_frame(32'h04030201, 4, 1'b1, 16'd4);
    start_frame(32'h04030201);
    tick(8);
    force dut.w_en_level = 1'b1;
    i_enable = 1'b0;
    tick(2);
    i_enable = 1'b1;
    tick(3);
    chk("ovr_before_edge", 32'(o_overrun), 32'd0);
    i_clr_overrun = 1'b1;
    tick(1);
    i_clr_overrun = 1'b0;
    chk("ovr_set_wins", 32'(o_overrun), 32'd1);
    wait_done("ovr2_done");
    release dut.w_en_level;

    // Frame counter wrap.
    force dut.r_frame_cnt = 16'hFFFF;
    tick(1);
    release dut.r_frame_cnt;
    tick(1);
    chk("cnt_preload", 32'(o_frame_cnt), 32'hFFFF);
    push_frame(32'h5A6B7C8D, 4, 1'b1, 16'h0000);
    start_frame(32'h5A6B7C8D);
    wait_done("wrap_done");
    chk("cnt_wrapped", 32'(o_frame_cnt), 32'd0);
    tick(3);

    chk("sb_bytes_drained", 32'(exp_bytes.size()), 32'd0);
    chk("sb_cnt_drained", 32'(exp_cnt.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
